osc_monitor: RTL and testbench
==============================

Name: osc_monitor

Overview:
- Clocked, parametrised successor to the single-net combinational oscillation flag.
- Watches NUM_CH asynchronous logic-loop nets and counts toggles per channel inside a programmable cycle window.
- Raises a sticky per-channel oscillation flag, an aggregate flag, an interrupt pulse and an event counter.
- Sits beside the combinational loop logic as its observability and safety monitor.

Parameters:
NUM_CH, 8, number of monitored nets (>=1)
WINDOW, 16, observation window length in clk cycles (>=2)
THRESH, 2, toggles within one window that declare oscillation (1..WINDOW)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
EDGE_MODE, 0, 0 = count both edges; 1 = count rising edges only
EVT_W, 8, event counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  monitor run enable
clr  in  1  synchronous clear of sticky flags and event counter
sig_in  in  NUM_CH  monitored asynchronous nets
osc_ch  out  NUM_CH  sticky per-channel oscillation flags
osc_flag  out  1  OR of osc_ch
irq  out  1  1-cycle pulse when any osc_ch bit goes 0->1
window_tick  out  1  1-cycle pulse on the last cycle of each window
evt_cnt  out  EVT_W  saturating count of threshold events

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; sync chains, prev, toggle counters and win_cnt cleared; osc_ch=0, osc_flag=0, irq=0, window_tick=0, evt_cnt=0.
- Synchroniser: each sig_in bit passes through SYNC_STAGES flops; s_last is the final stage. The chain runs in every state.
- FSM states:
  - IDLE: counters held at 0. enable=1 -> PRIME.
  - PRIME (1 cycle): prev<=s_last, no counting, win_cnt<=0 -> RUN. This suppresses a spurious toggle at start.
  - RUN: counting is active. enable=0 in any state -> IDLE next edge; toggle counters and win_cnt clear, osc_ch and evt_cnt are retained.
- Toggle detect in RUN: tog = s_last ^ prev (EDGE_MODE 0) or s_last & ~prev (EDGE_MODE 1). prev<=s_last every RUN cycle.
- Per-channel counter: width clog2(THRESH+1). It increments on tog and saturates at THRESH. Hit = tog & (cnt+1 >= THRESH) with cnt < THRESH, so each channel hits at most once per window.
- Latency: sig_in change sampled at edge E -> osc_ch bit set at edge E+SYNC_STAGES (first possible).
- Window: win_cnt counts 0..WINDOW-1 in RUN. window_tick=1 while win_cnt==WINDOW-1.
  - On that edge all toggle counters clear to 0; no carry into the next window.
  - A toggle in the last cycle is still evaluated for hit before the clear.
- Sticky flags: osc_ch[i] set on hit[i]. clr clears all bits; on simultaneous clr and hit for the same channel, set wins.
- osc_flag: combinational OR of registered osc_ch.
- irq: registered. 1 for one cycle after any edge where a bit of osc_ch goes 0->1; several simultaneous bits give a single pulse.
- evt_cnt: +1 per edge with any hit (not per channel); saturates at 2^EVT_W-1. clr resets it to 0; if clr and hit coincide, the result is 1.
- clr does not affect toggle counters, win_cnt or the FSM.
- Reset mid-window: all state returns to reset values immediately; no pulse is emitted.

Test Plan (NUM_CH=4, WINDOW=8, THRESH=2, SYNC_STAGES=2, EDGE_MODE=0 unless noted):
- Reset/enable: rst_n low then high, enable=1 with sig_in=4'b1010 constant for 20 cycles -> osc_ch=0, irq never 1, window_tick pulses every 8 cycles after PRIME.
- Single oscillator: ch1 toggles every 2 cycles -> osc_ch=4'b0010 set 2 edges after the 2nd sampled toggle; irq one pulse; evt_cnt=1, and +1 each subsequent window.
- Window boundary: ch0 toggles once in the last cycle of a window and once in the first cycle of the next -> no flag. Toggles twice in the last 2 cycles of one window -> flag set.
- Simultaneous events: ch2 and ch3 reach threshold on the same edge with clr=1 that cycle -> osc_ch=4'b1100, one irq pulse, evt_cnt=1.
- EDGE_MODE=1: ch0 driven 1->0->1->0 -> 2 rising edges needed; only the 0->1 transitions count; flag on the second rising edge.
- Saturation and mid-run control: EVT_W=2, oscillate ch0 for 6 windows -> evt_cnt sticks at 3. Deassert enable mid-window, then reassert -> counting restarts cleanly after PRIME. Assert rst_n low mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/osc_monitor.sv
// Clocked oscillation monitor: synchronises NUM_CH asynchronous nets, counts toggles per
// channel inside a repeating cycle window and raises sticky flags, an irq pulse and an event count.
module osc_monitor #(
    parameter int NUM_CH      = 8,
    parameter int WINDOW      = 16,
    parameter int THRESH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int EVT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clr,
    input  logic [NUM_CH-1:0] sig_in,
    output logic [NUM_CH-1:0] osc_ch,
    output logic              osc_flag,
    output logic              irq,
    output logic              window_tick,
    output logic [EVT_W-1:0]  evt_cnt
);
    localparam int CNT_W = $clog2(THRESH + 1);
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_HIT  = CNT_W'(THRESH - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                                state;
    state_t                                state_next;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0]    sync_q;
    logic [NUM_CH-1:0]                     s_last;
    logic [NUM_CH-1:0]                     prev;
    logic [NUM_CH-1:0]                     tog;
    logic [NUM_CH-1:0]                     hit;
    logic [NUM_CH-1:0]                     osc_next;
    logic [CNT_W-1:0]                      tog_cnt [NUM_CH];
    logic [WIN_W-1:0]                      win_cnt;
    logic                                  run_active;
    logic                                  win_last;
    logic                                  any_hit;

    // Synchroniser runs regardless of FSM state so s_last is settled when PRIME samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = PRIME;
            PRIME:   state_next = enable ? RUN : IDLE;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A RUN cycle with enable low behaves like IDLE: no counting, counters cleared at its edge.
    assign run_active  = (state == RUN) && enable;
    assign win_last    = (win_cnt == WIN_LAST);
    assign window_tick = run_active && win_last;
    assign tog         = (EDGE_MODE == 0) ? (s_last ^ prev) : (s_last & ~prev);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = run_active && tog[i] && (tog_cnt[i] == CNT_HIT);
        end
    end

    assign any_hit = |hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            win_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) tog_cnt[i] <= '0;
        end else if (state == PRIME) begin
            prev    <= s_last;
            win_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) tog_cnt[i] <= '0;
        end else if (run_active) begin
            prev    <= s_last;
            win_cnt <= win_last ? '0 : win_cnt + WIN_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (win_last) begin
                    tog_cnt[i] <= '0;
                end else if (tog[i] && (tog_cnt[i] != CNT_SAT)) begin
                    tog_cnt[i] <= tog_cnt[i] + CNT_W'(1);
                end
            end
        end else begin
            win_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) tog_cnt[i] <= '0;
        end
    end

    // Set beats clear so a hit landing on a clr cycle is never lost.
    assign osc_next = (clr ? '0 : osc_ch) | hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_ch  <= '0;
            irq     <= 1'b0;
            evt_cnt <= '0;
        end else begin
            osc_ch <= osc_next;
            irq    <= |(hit & ~osc_ch);
            if (clr) begin
                evt_cnt <= EVT_W'(any_hit);
            end else if (any_hit && (evt_cnt != {EVT_W{1'b1}})) begin
                evt_cnt <= evt_cnt + EVT_W'(1);
            end
        end
    end

    assign osc_flag = |osc_ch;

endmodule

// File: tb/tb_osc_monitor.sv
// Bench for osc_monitor: two instances (both-edge/EVT_W=2 and rising-edge/EVT_W=8) share
// stimulus and are checked every cycle against a window/toggle-count model plus literal pins.
module tb_osc_monitor;
    localparam int NCH = 4;
    localparam int WIN = 8;
    localparam int TH  = 2;
    localparam int SYN = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           clr;
    logic [NCH-1:0] sig_in;

    logic [NCH-1:0] oa_osc, ob_osc;
    logic           oa_flag, ob_flag, oa_irq, ob_irq, oa_tick, ob_tick;
    logic [1:0]     oa_evt;
    logic [7:0]     ob_evt;

    osc_monitor #(.NUM_CH(NCH), .WINDOW(WIN), .THRESH(TH), .SYNC_STAGES(SYN),
                  .EDGE_MODE(0), .EVT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .sig_in(sig_in),
        .osc_ch(oa_osc), .osc_flag(oa_flag), .irq(oa_irq), .window_tick(oa_tick),
        .evt_cnt(oa_evt)
    );

    osc_monitor #(.NUM_CH(NCH), .WINDOW(WIN), .THRESH(TH), .SYNC_STAGES(SYN),
                  .EDGE_MODE(1), .EVT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .sig_in(sig_in),
        .osc_ch(ob_osc), .osc_flag(ob_flag), .irq(ob_irq), .window_tick(ob_tick),
        .evt_cnt(ob_evt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_cnt_a = 0;
    int irq_cnt_a = 0;
    logic [NCH-1:0] sv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sampled input history (hist[0] = value taken at the latest edge), count of consecutive
    // enabled edges, and raw per-window toggle counts per instance.
    logic [NCH-1:0] hist[$];
    int             run_cnt;
    int             wtog [2][NCH];
    logic [NCH-1:0] m_osc [2];
    logic           m_irq [2];
    int             m_evt [2];
    logic [19:0]    exp_q[$];

    function automatic logic [19:0] pack_exp();
        return {m_osc[0], m_irq[0], 2'(m_evt[0]), m_osc[1], m_irq[1], 8'(m_evt[1])};
    endfunction

    function automatic int cur_pos();
        return (run_cnt >= 2) ? (run_cnt - 2) % WIN : -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= SYN; i++) hist.push_back('0);
        run_cnt = 0;
        for (int d = 0; d < 2; d++) begin
            m_osc[d] = '0;
            m_irq[d] = 1'b0;
            m_evt[d] = 0;
            for (int c = 0; c < NCH; c++) wtog[d][c] = 0;
        end
        exp_q.delete();
        exp_q.push_back(pack_exp());
    endtask

    task automatic model_step();
        logic [NCH-1:0] s, p, hit;
        bit active;
        int pos;
        s = hist[SYN-1];
        p = hist[SYN];
        active = (run_cnt >= 2) && enable;
        pos = active ? (run_cnt - 2) % WIN : 0;
        for (int d = 0; d < 2; d++) begin
            hit = '0;
            for (int c = 0; c < NCH; c++) begin
                if (active) begin
                    if ((s[c] != p[c]) && (d == 0 || s[c] == 1'b1)) begin
                        wtog[d][c]++;
                        if (wtog[d][c] == TH) hit[c] = 1'b1;
                    end
                    if (pos == WIN - 1) wtog[d][c] = 0;
                end else begin
                    wtog[d][c] = 0;
                end
            end
            m_irq[d] = |(hit & ~m_osc[d]);
            m_osc[d] = (clr ? '0 : m_osc[d]) | hit;
            if (clr) m_evt[d] = (hit != '0) ? 1 : 0;
            else if (hit != '0 && m_evt[d] < ((d == 0) ? 3 : 255)) m_evt[d]++;
        end
        hist.push_front(sig_in);
        void'(hist.pop_back());
        run_cnt = enable ? run_cnt + 1 : 0;
        exp_q.push_back(pack_exp());
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [19:0] e;
        logic        e_tick;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            e_tick = rst_n && (run_cnt >= 2) && enable && (((run_cnt - 2) % WIN) == WIN - 1);
            chk("a_osc_ch",  oa_osc,  e[19:16]);
            chk("a_osc_flag", oa_flag, |e[19:16]);
            chk("a_irq",     oa_irq,  e[15]);
            chk("a_tick",    oa_tick, e_tick);
            chk("a_evt",     oa_evt,  e[14:13]);
            chk("b_osc_ch",  ob_osc,  e[12:9]);
            chk("b_osc_flag", ob_flag, |e[12:9]);
            chk("b_irq",     ob_irq,  e[8]);
            chk("b_tick",    ob_tick, e_tick);
            chk("b_evt",     ob_evt,  e[7:0]);
        end
        if (oa_tick) tick_cnt_a++;
        if (oa_irq) irq_cnt_a++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic en, input logic c, input logic [NCH-1:0] s);
        enable = en;
        clr    = c;
        sig_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pos(input int p);
        int n = 0;
        while (cur_pos() != p && n < 40) begin
            step(1'b1, 1'b0, sv);
            n++;
        end
        chk("goto_pos", cur_pos(), p);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, sv);
    endtask

    int rate [NCH];

    initial begin
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; sig_in = '0; sv = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_a_osc", oa_osc, 4'b0000);
        chk("reset_a_evt", oa_evt, 2'd0);
        chk("reset_b_osc", ob_osc, 4'b0000);
        chk("reset_a_irq", oa_irq, 1'b0);

        // Constant input: no flags, tick every WIN cycles after PRIME.
        sv = 4'b1010;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, sv);
        tick_cnt_a = 0; irq_cnt_a = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, sv);
        chk("const_ticks", tick_cnt_a, 2);
        chk("const_irq", irq_cnt_a, 0);
        chk("const_osc", oa_osc, 4'b0000);

        // Single oscillator on ch1.
        irq_cnt_a = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) sv[1] = ~sv[1];
            step(1'b1, 1'b0, sv);
        end
        quiet(3);
        chk("single_osc", oa_osc, 4'b0010);
        chk("single_flag", oa_flag, 1'b1);
        chk("single_irq", irq_cnt_a, 1);

        // Window boundary: one toggle at the last cycle, one at the first of the next.
        step(1'b1, 1'b1, sv);
        goto_pos(5);
        sv[0] = ~sv[0]; step(1'b1, 1'b0, sv);
        sv[0] = ~sv[0]; step(1'b1, 1'b0, sv);
        quiet(4);
        chk("split_a_osc", oa_osc, 4'b0000);
        chk("split_b_osc", ob_osc, 4'b0000);
        goto_pos(4);
        sv[0] = ~sv[0]; step(1'b1, 1'b0, sv);
        sv[0] = ~sv[0]; step(1'b1, 1'b0, sv);
        quiet(3);
        chk("last2_a_osc", oa_osc, 4'b0001);
        chk("last2_b_osc", ob_osc, 4'b0000);

        // Simultaneous hits on ch2/ch3 with clr on the hit cycle.
        step(1'b1, 1'b1, sv);
        irq_cnt_a = 0;
        goto_pos(0);
        sv[3:2] = ~sv[3:2]; step(1'b1, 1'b0, sv);
        sv[3:2] = ~sv[3:2]; step(1'b1, 1'b0, sv);
        step(1'b1, 1'b0, sv);
        step(1'b1, 1'b1, sv);
        quiet(3);
        chk("simul_osc", oa_osc, 4'b1100);
        chk("simul_evt", oa_evt, 2'd1);
        chk("simul_irq", irq_cnt_a, 1);

        // Rising-edge mode: ch0 1,0,1,0.
        step(1'b1, 1'b1, sv);
        goto_pos(0);
        sv[0] = 1'b1; step(1'b1, 1'b0, sv);
        sv[0] = 1'b0; step(1'b1, 1'b0, sv);
        sv[0] = 1'b1; step(1'b1, 1'b0, sv);
        sv[0] = 1'b0; step(1'b1, 1'b0, sv);
        chk("edge_a_early", oa_osc, 4'b0001);
        chk("edge_b_early", ob_osc, 4'b0000);
        quiet(3);
        chk("edge_b_late", ob_osc, 4'b0001);

        // Saturation: ch0 toggles every cycle for six windows.
        step(1'b1, 1'b1, sv);
        goto_pos(0);
        for (int k = 0; k < 48; k++) begin
            sv[0] = ~sv[0];
            step(1'b1, 1'b0, sv);
        end
        quiet(3);
        chk("sat_a_evt", oa_evt, 2'd3);
        chk("sat_b_evt", ob_evt, 8'd6);

        // Enable drop mid-window, then clean restart after PRIME.
        step(1'b1, 1'b1, sv);
        goto_pos(1);
        sv[0] = ~sv[0]; step(1'b1, 1'b0, sv);
        quiet(2);
        step(1'b0, 1'b0, sv);
        step(1'b0, 1'b0, sv);
        step(1'b1, 1'b0, sv);
        step(1'b1, 1'b0, sv);
        sv[0] = ~sv[0]; step(1'b1, 1'b0, sv);
        quiet(5);
        chk("restart_tick_pre", oa_tick, 1'b0);
        quiet(1);
        chk("restart_tick_a", oa_tick, 1'b1);
        chk("restart_tick_b", ob_tick, 1'b1);
        chk("restart_osc", oa_osc, 4'b0000);

        // Reset mid-window.
        for (int i = 0; i < 6; i++) begin
            sv[1] = ~sv[1];
            step(1'b1, 1'b0, sv);
        end
        chk("prereset_flag", oa_flag, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_osc", oa_osc, 4'b0000);
        chk("rst_a_flag", oa_flag, 1'b0);
        chk("rst_a_irq", oa_irq, 1'b0);
        chk("rst_a_tick", oa_tick, 1'b0);
        chk("rst_a_evt", oa_evt, 2'd0);
        chk("rst_b_osc", ob_osc, 4'b0000);
        chk("rst_b_evt", ob_evt, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic with varying per-channel toggle rates.
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) begin
                for (int c = 0; c < NCH; c++) rate[c] = $urandom_range(0, 8);
            end
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) < rate[c]) sv[c] = ~sv[c];
            end
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            step(($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, sv);
        end
        quiet(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
